// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single memory port.
// Data has priority, bounded by a starvation counter; stalled transfers abort after TIMEOUT cycles.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                err,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SW     = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int TW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

  state_t              state_reg, state_next;
  logic                grant_i_reg, grant_i_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [STRB_W-1:0]   wstrb_reg, wstrb_next;
  logic [SW-1:0]       starve_reg, starve_next;
  logic [TW-1:0]       tmo_reg, tmo_next;
  logic                mem_req_reg, mem_req_next;
  logic                i_ack_reg, i_ack_next;
  logic                d_ack_reg, d_ack_next;
  logic [DATA_W-1:0]   i_rdata_reg, i_rdata_next;
  logic [DATA_W-1:0]   d_rdata_reg, d_rdata_next;
  logic                err_reg, err_next;
  logic                busy_reg, busy_next;
  logic [DATA_W-1:0]   rdata_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      grant_i_reg <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      starve_reg  <= '0;
      tmo_reg     <= '0;
      mem_req_reg <= 1'b0;
      i_ack_reg   <= 1'b0;
      d_ack_reg   <= 1'b0;
      i_rdata_reg <= '0;
      d_rdata_reg <= '0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      grant_i_reg <= grant_i_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
      starve_reg  <= starve_next;
      tmo_reg     <= tmo_next;
      mem_req_reg <= mem_req_next;
      i_ack_reg   <= i_ack_next;
      d_ack_reg   <= d_ack_next;
      i_rdata_reg <= i_rdata_next;
      d_rdata_reg <= d_rdata_next;
      err_reg     <= err_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    grant_i_next = grant_i_reg;
    we_next      = we_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    starve_next  = starve_reg;
    tmo_next     = tmo_reg;
    mem_req_next = 1'b0;
    i_ack_next   = 1'b0;
    d_ack_next   = 1'b0;
    i_rdata_next = '0;
    d_rdata_next = '0;
    err_next     = 1'b0;
    // Stores return zero to the requester regardless of what the memory drives.
    rdata_sel    = we_reg ? '0 : mem_rdata;

    case (state_reg)
      IDLE: begin
        if (i_req || d_req) begin
          state_next   = XFER;
          mem_req_next = 1'b1;
          tmo_next     = '0;
          if (i_req && (!d_req || starve_reg == STARVE_TOP)) begin
            grant_i_next = 1'b1;
            we_next      = 1'b0;
            addr_next    = i_addr;
            wdata_next   = '0;
            wstrb_next   = '0;
            starve_next  = '0;
          end else begin
            grant_i_next = 1'b0;
            we_next      = d_we;
            addr_next    = d_addr;
            wdata_next   = d_wdata;
            wstrb_next   = d_wstrb;
            if (!i_req)
              starve_next = '0;
            else if (starve_reg != STARVE_TOP)
              starve_next = starve_reg + 1'b1;
          end
        end
      end
      XFER: begin
        if (mem_ready) begin
          state_next   = ACK;
          tmo_next     = '0;
          i_ack_next   = grant_i_reg;
          d_ack_next   = !grant_i_reg;
          i_rdata_next = grant_i_reg ? rdata_sel : '0;
          d_rdata_next = grant_i_reg ? '0 : rdata_sel;
        end else if (tmo_reg == TMO_LAST) begin
          // Abort: ack the requester with err and zero data.
          state_next = ACK;
          tmo_next   = '0;
          i_ack_next = grant_i_reg;
          d_ack_next = !grant_i_reg;
          err_next   = 1'b1;
        end else begin
          tmo_next     = tmo_reg + 1'b1;
          mem_req_next = 1'b1;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_wstrb = wstrb_reg;
  assign i_ack     = i_ack_reg;
  assign d_ack     = d_ack_reg;
  assign i_rdata   = i_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign err       = err_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a driver predicts each ack from arbitration rules and a
// reference memory; a memory responder and an ack monitor check the DUT independently.
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, SMAX = 4, TMO = 255, NEVER = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req, i_ack, d_req, d_we, d_ack;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic [3:0]    d_wstrb, mem_wstrb;
  logic          mem_req, mem_we, mem_ready, err, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .err(err), .busy(busy)
  );

  typedef struct {
    bit          port_i;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } ack_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  strb;
    bit          data_port;
    int          waits;
  } mem_t;

  ack_t        ack_q[$];
  mem_t        mem_q[$];
  logic [31:0] ref_mem [16];
  logic [31:0] store   [16];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  // Requests currently held by the two requesters
  bit          ip, dp;
  logic [31:0] ia, da, dwd;
  logic        dwe;
  logic [3:0]  dst;
  int          ref_starve = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  // Called at a falling edge with the DUT idle; returns at the idle falling edge after the ack.
  task automatic serve(input int waits);
    ack_t a;
    mem_t m;
    bit   gi, tmo, done;
    int   c;
    i_req = ip; i_addr = ia;
    d_req = dp; d_we = dwe; d_addr = da; d_wdata = dwd; d_wstrb = dst;
    if (!ip && !dp) begin
      @(negedge clk);
      chk("idle_stay", 64'(busy), 64'(0));
      return;
    end
    c  = cyc;
    gi = ip && (!dp || ref_starve == SMAX);
    if (gi || !ip) ref_starve = 0;
    else if (ref_starve < SMAX) ref_starve++;
    tmo         = (waits >= TMO);
    m.addr      = gi ? ia : da;
    m.we        = gi ? 1'b0 : dwe;
    m.strb      = gi ? 4'h0 : dst;
    m.wdata     = dwd;
    m.data_port = !gi;
    m.waits     = waits;
    a.port_i    = gi;
    a.err       = tmo;
    a.cyc       = tmo ? c + 1 + TMO : c + 2 + waits;
    a.rdata     = (tmo || m.we) ? 32'h0 : ref_mem[m.addr[5:2]];
    if (!tmo && m.we)
      for (int b = 0; b < 4; b++)
        if (m.strb[b]) ref_mem[m.addr[5:2]][8*b +: 8] = m.wdata[8*b +: 8];
    ack_q.push_back(a);
    mem_q.push_back(m);
    done = 0;
    for (int n = 0; n < 600 && !done; n++) begin
      @(negedge clk);
      if (i_ack || d_ack) done = 1;
      else begin
        // Requester inputs are noise once the grant is taken
        i_req = 1'($urandom_range(0, 1)); d_req = 1'($urandom_range(0, 1));
        i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
        d_we = 1'($urandom_range(0, 1)); d_wstrb = 4'($urandom_range(0, 15));
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL ack_wait: no ack within 600 cycles, want one");
      $fatal(1, "ack wait bound expired");
    end
    if (gi) ip = 0; else dp = 0;
    @(negedge clk);
  endtask

  // Memory responder: plays back the planned wait count and checks the request fields every cycle
  initial begin
    mem_t cur;
    bit   in_x;
    int   cnt;
    in_x = 0; cnt = 0; mem_ready = 1'b0; mem_rdata = '0;
    cur = '{addr: '0, wdata: '0, we: 1'b0, strb: '0, data_port: 1'b0, waits: 0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_x = 0; mem_ready = 1'b0;
      end else if (!mem_req) begin
        if (in_x) begin
          chk("timeout_len", 64'(cnt), 64'(TMO));
          chk("timeout_planned", 64'(cur.waits >= TMO), 64'(1));
          in_x = 0;
        end
        mem_ready = 1'b0;
      end else begin
        if (!in_x) begin
          if (mem_q.size() == 0) begin
            total++; bad++;
            $display("FAIL mem_unexpected: mem_req=1 at cycle %0d, want 0", cyc);
            cur = '{addr: mem_addr, wdata: mem_wdata, we: mem_we, strb: mem_wstrb,
                    data_port: 1'b1, waits: 0};
          end else cur = mem_q.pop_front();
          in_x = 1; cnt = 0;
        end
        chk("mem_addr", 64'(mem_addr), 64'(cur.addr));
        chk("mem_we", 64'(mem_we), 64'(cur.we));
        chk("mem_wstrb", 64'(mem_wstrb), 64'(cur.strb));
        if (cur.data_port) chk("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
        chk("busy_xfer", 64'(busy), 64'(1));
        if (cnt == cur.waits) begin
          mem_ready = 1'b1;
          mem_rdata = mem_we ? $urandom : store[mem_addr[5:2]];
          if (mem_we)
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b]) store[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          in_x = 0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          cnt++;
        end
      end
    end
  end

  // Ack monitor
  initial begin
    ack_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("ack_excl", 64'(i_ack & d_ack), 64'(0));
        if (i_ack || d_ack) begin
          if (ack_q.size() == 0) begin
            total++; bad++;
            $display("FAIL ack_unexpected: i_ack=%0b d_ack=%0b at cycle %0d, want none",
                     i_ack, d_ack, cyc);
          end else begin
            e = ack_q.pop_front();
            chk("ack_port_i", 64'(i_ack), 64'(e.port_i));
            chk("ack_rdata", 64'(e.port_i ? i_rdata : d_rdata), 64'(e.rdata));
            chk("other_rdata", 64'(e.port_i ? d_rdata : i_rdata), 64'(0));
            chk("ack_err", 64'(err), 64'(e.err));
            chk("ack_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
      end
    end
  end

  initial begin
    mem_t m;
    int   w;
    for (int k = 0; k < 16; k++) begin
      ref_mem[k] = 32'h1000_0000 + 32'(k) * 32'h0101_0101;
      store[k]   = 32'h1000_0000 + 32'(k) * 32'h0101_0101;
    end
    ref_mem[4] = 32'hDEAD_BEEF;
    store[4]   = 32'hDEAD_BEEF;
    ip = 0; dp = 0; ia = 0; da = 0; dwd = 0; dwe = 0; dst = 0;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;

    repeat (3) @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_acks", 64'({i_ack, d_ack, err}), 64'(0));
    chk("rst_mem_fields", 64'({mem_we, mem_wstrb, mem_addr}), 64'(0));
    chk("rst_rdata", 64'({i_rdata, d_rdata}), 64'(0));
    #1 rst = 1'b1;

    // Single load, store with three waits, readback of the merged word
    dp = 1; dwe = 0; da = 32'h10; serve(0);
    dp = 1; dwe = 1; da = 32'h10; dwd = 32'h1234; dst = 4'h3; serve(3);
    dp = 1; dwe = 0; da = 32'h10; serve(0);
    // Instruction fetch with a memory that never answers
    ip = 1; ia = 32'h8; serve(NEVER);

    // Both ports continuously requesting
    for (int n = 0; n < 10; n++) begin
      if (!ip) begin ip = 1; ia = rand_addr(); end
      if (!dp) begin
        dp = 1; dwe = 1'($urandom_range(0, 1)); da = rand_addr();
        dwd = $urandom; dst = 4'($urandom_range(0, 15));
      end
      serve(0);
    end

    // Reset on the second wait cycle of an instruction fetch
    ip = 1; ia = 32'h24; dp = 0;
    i_req = 1; i_addr = ia; d_req = 0;
    m = '{addr: ia, wdata: '0, we: 1'b0, strb: 4'h0, data_port: 1'b0, waits: NEVER};
    mem_q.push_back(m);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_mem_req", 64'(mem_req), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_acks", 64'({i_ack, d_ack}), 64'(0));
    ref_starve = 0;
    @(negedge clk);
    chk("midrst_fields", 64'({err, mem_addr}), 64'(0));
    #1 rst = 1'b1;
    serve(1);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      if (!ip && $urandom_range(0, 9) < 6) begin ip = 1; ia = rand_addr(); end
      if (!dp && $urandom_range(0, 9) < 6) begin
        dp = 1; dwe = 1'($urandom_range(0, 1)); da = rand_addr();
        dwd = $urandom; dst = 4'($urandom_range(0, 15));
      end
      w = ($urandom_range(0, 79) == 0) ? NEVER : int'($urandom_range(0, 3));
      serve(w);
    end

    i_req = 0; d_req = 0;
    repeat (5) @(negedge clk);
    chk("queues_drained", 64'(ack_q.size() + mem_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
